// File: rtl/awb_pkg.sv
// Shared types and constants for the gray-world auto-white-balance estimator.
package awb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_R  = 2'd1,
        DIV_B  = 2'd2,
        UPDATE = 2'd3
    } awb_state_t;

    localparam int GAIN_W = 13;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 13'h0400;
    // Largest coefficient the downstream multiplier accepts.
    localparam logic [GAIN_W-1:0] GAIN_MAX = 13'h1FFF;

    // One quotient bit per cycle over the whole (sum << frac) dividend.
    function automatic int div_cycles(input int sum_w, input int frac_w);
        return sum_w + frac_w;
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, done pulses
// for one cycle once all DIVIDEND_W bits have been resolved.
module udiv_seq #(
    parameter int DIVIDEND_W = 42,
    parameter int DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic                  running;
    logic [CNT_W-1:0]      cnt;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  dvs;

    logic [DIVISOR_W:0]    rem_sh;
    logic                  fits;
    logic [DIVISOR_W-1:0]  diff;

    // The partial remainder stays below the divisor, so the low bits of the
    // subtraction are exact whenever the trial fits.
    always_comb begin
        rem_sh = {rem, quo[DIVIDEND_W-1]};
        fits   = (rem_sh >= {1'b0, dvs});
        diff   = rem_sh[DIVISOR_W-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running <= 1'b1;
                cnt     <= CNT_W'(DIVIDEND_W);
            end else if (running) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (running) begin
            rem <= fits ? diff : rem_sh[DIVISOR_W-1:0];
            quo <= {quo[DIVIDEND_W-2:0], fits};
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/awb_gray_world.sv
// Gray-world AWB: per-frame channel sums, R/B gains equalised to the G mean
// computed during vblank, published as Q3.10 coefficients for the RGB multiplier.
module awb_gray_world
    import awb_pkg::*;
#(
    parameter int PIXEL_WIDTH        = 8,
    parameter int COE_WIDTH          = 16,
    parameter int COE_FRACTION_WIDTH = 10,
    parameter int SUM_WIDTH          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIXEL_WIDTH*3-1:0] di_i,
    input  logic                     de_i,
    input  logic                     vs_i,
    input  logic                     en_i,
    output logic [COE_WIDTH*3-1:0]   coe_o,
    output logic                     coe_vld_o,
    output logic                     busy_o
);

    localparam int N = div_cycles(SUM_WIDTH, COE_FRACTION_WIDTH);
    localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

    function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] sum,
                                                     input logic [PIXEL_WIDTH-1:0] pix);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, sum} + {{(SUM_WIDTH + 1 - PIXEL_WIDTH){1'b0}}, pix};
        return s[SUM_WIDTH] ? SUM_MAX : s[SUM_WIDTH-1:0];
    endfunction

    // An empty channel has no meaningful ratio, so it is left at unity.
    function automatic logic [COE_WIDTH-1:0] gain_slot(input logic [N-1:0] q,
                                                       input logic div_zero);
        if (div_zero)
            return COE_WIDTH'(GAIN_UNITY);
        if (q > N'(GAIN_MAX))
            return COE_WIDTH'(GAIN_MAX);
        return COE_WIDTH'(q[GAIN_W-1:0]);
    endfunction

    awb_state_t            state_q, state_d;
    logic                  vs_q;
    logic                  primed;
    logic                  frame_end;
    logic                  snap_take;
    logic [SUM_WIDTH-1:0]  sum  [3];
    logic [SUM_WIDTH-1:0]  snap [3];

    logic                  div_start;
    logic                  div_done;
    logic [N-1:0]          dividend;
    logic [SUM_WIDTH-1:0]  divisor;
    logic [N-1:0]          quotient;
    logic                  take_r;
    logic                  take_all;
    logic [COE_WIDTH-1:0]  gain_r_q;

    assign frame_end = vs_i & ~vs_q;
    assign snap_take = frame_end & (state_q == IDLE) & en_i & primed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q   <= 1'b0;
            primed <= 1'b0;
        end else begin
            vs_q <= vs_i;
            if (frame_end)
                primed <= 1'b1;
        end
    end

    // The edge-cycle pixel opens the new frame; the snapshot takes the old sums.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                sum[c]  <= '0;
                snap[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (frame_end)
                    sum[c] <= de_i ? SUM_WIDTH'(di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]) : '0;
                else if (de_i)
                    sum[c] <= sat_add(sum[c], di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
                if (snap_take)
                    snap[c] <= sum[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // R divide starts in the edge cycle straight from the live sums, so the
    // snapshot is only needed once the B divide begins.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        take_r    = 1'b0;
        take_all  = 1'b0;
        dividend  = {snap[1], {COE_FRACTION_WIDTH{1'b0}}};
        divisor   = snap[2];
        case (state_q)
            IDLE: begin
                dividend = {sum[1], {COE_FRACTION_WIDTH{1'b0}}};
                divisor  = sum[0];
                if (snap_take) begin
                    div_start = 1'b1;
                    state_d   = DIV_R;
                end
            end
            DIV_R: begin
                if (div_done) begin
                    take_r    = 1'b1;
                    div_start = 1'b1;
                    state_d   = DIV_B;
                end
            end
            DIV_B: begin
                if (div_done) begin
                    take_all = 1'b1;
                    state_d  = UPDATE;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    udiv_seq #(
        .DIVIDEND_W (N),
        .DIVISOR_W  (SUM_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (take_r)
            gain_r_q <= gain_slot(quotient, snap[0] == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coe_o     <= {3{COE_WIDTH'(GAIN_UNITY)}};
            coe_vld_o <= 1'b0;
        end else begin
            coe_vld_o <= take_all;
            if (take_all)
                coe_o <= {gain_slot(quotient, snap[2] == '0), COE_WIDTH'(GAIN_UNITY), gain_r_q};
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_awb_gray_world.sv
// Bench for awb_gray_world: directed frames plus randomized frames checked every
// cycle against a frame-level gray-world reference model.
module tb_awb_gray_world;

    localparam int SW  = 32;
    localparam int FW  = 10;
    localparam int LAT = 2 * (SW + FW) + 2;
    localparam logic [15:0] UNITY = 16'h0400;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] di_i;
    logic        de_i, vs_i, en_i;
    logic [47:0] coe_o;
    logic        coe_vld_o, busy_o;

    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    awb_gray_world dut (
        .clk       (clk),
        .rst       (rst),
        .di_i      (di_i),
        .de_i      (de_i),
        .vs_i      (vs_i),
        .en_i      (en_i),
        .coe_o     (coe_o),
        .coe_vld_o (coe_vld_o),
        .busy_o    (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_coe(input string tag, input logic [15:0] r, input logic [15:0] g,
                           input logic [15:0] b);
        chk(tag, coe_o, {b, g, r});
    endtask

    // Reference model: frame sums, primed flag, and one pending result.
    longint      m_sum [3];
    bit          m_primed;
    bit          m_vs;
    bit          m_act;
    int          m_e;
    int          last_edge;
    bit          in_reset;
    logic [15:0] m_coe  [3];
    logic [15:0] m_pend [3];

    function automatic logic [15:0] ref_gain(input longint g, input longint x);
        longint q;
        if (x == 0) return UNITY;
        q = (g * 1024) / x;
        if (q > 64'h1FFF) return 16'h1FFF;
        return q[15:0];
    endfunction

    function automatic bit busy_at(input int c);
        return m_act && (c >= m_e) && (c <= m_e + LAT);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_sum[c] = 0;
            m_coe[c] = UNITY;
        end
        m_primed = 0;
        m_vs     = 0;
        m_act    = 0;
    endtask

    task automatic step(input logic [23:0] px, input logic de, input logic vs, input logic en);
        int cur;
        bit vld_exp;
        di_i = px; de_i = de; vs_i = vs; en_i = en;
        @(posedge clk);
        #1;
        cur = cyc;
        if (!in_reset) begin
            if (vs && !m_vs) begin
                last_edge = cur;
                if (m_primed && en && !busy_at(cur - 1)) begin
                    m_pend[0] = ref_gain(m_sum[1], m_sum[0]);
                    m_pend[1] = UNITY;
                    m_pend[2] = ref_gain(m_sum[1], m_sum[2]);
                    m_act = 1;
                    m_e   = cur;
                end
                m_primed = 1;
                for (int c = 0; c < 3; c++) m_sum[c] = de ? longint'(px[8*c +: 8]) : 0;
            end else if (de) begin
                for (int c = 0; c < 3; c++) begin
                    m_sum[c] = m_sum[c] + longint'(px[8*c +: 8]);
                    if (m_sum[c] > 64'hFFFF_FFFF) m_sum[c] = 64'hFFFF_FFFF;
                end
            end
            m_vs = vs;
        end
        vld_exp = m_act && (cur == m_e + LAT);
        if (vld_exp) for (int c = 0; c < 3; c++) m_coe[c] = m_pend[c];
        chk("vld", coe_vld_o, vld_exp);
        chk("busy", busy_o, busy_at(cur));
        chk("coe", coe_o, {m_coe[2], m_coe[1], m_coe[0]});
    endtask

    task automatic idle(input int n);
        repeat (n) step(24'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int hold);
        #2 rst = 1'b0;
        in_reset = 1;
        model_reset();
        #1;
        chk("rst_coe", coe_o, {3{UNITY}});
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_vld", coe_vld_o, 1'b0);
        repeat (hold) step(24'h0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        in_reset = 0;
    endtask

    task automatic send_frame(input int npx, input bit rnd, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b, input logic en,
                              input logic edge_de, input logic [23:0] edge_px, input int tail);
        logic [23:0] px;
        for (int i = 0; i < npx; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) step(24'h0, 1'b0, 1'b0, en);
            px = rnd ? {b & 8'($urandom), g & 8'($urandom), r & 8'($urandom)} : {b, g, r};
            step(px, 1'b1, 1'b0, en);
        end
        step(edge_px, edge_de, 1'b1, en);
        step(24'h0, 1'b0, 1'b1, en);
        step(24'h0, 1'b0, 1'b0, en);
        repeat (tail) step(24'h0, 1'b0, 1'b0, en);
    endtask

    task automatic wait_vld(input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            step(24'h0, 1'b0, 1'b0, 1'b1);
            if (coe_vld_o) begin
                lat = cyc - last_edge;
                break;
            end
        end
        chk(tag, lat, LAT);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e1;
        logic [7:0] mr, mg, mb;
        int sel;
        logic en;

        rst = 1'b1;
        di_i = '0; de_i = 1'b0; vs_i = 1'b0; en_i = 1'b1;
        in_reset = 0;
        last_edge = 0;
        model_reset();
        #2;
        do_reset(4);

        // Partial first frame is ignored; the second one yields 2.0 and 4.0.
        send_frame(4, 0, 8'd64, 8'd128, 8'd32, 1'b1, 1'b0, 24'h0, 10);
        chk_coe("unprimed", UNITY, UNITY, UNITY);
        send_frame(4, 0, 8'd64, 8'd128, 8'd32, 1'b1, 1'b0, 24'h0, 0);
        wait_vld("lat_basic");
        chk_coe("basic", 16'h0800, UNITY, 16'h1000);
        idle(3);

        send_frame(2, 0, 8'd3, 8'd10, 8'd10, 1'b1, 1'b0, 24'h0, 0);
        wait_vld("lat_trunc");
        chk_coe("trunc", 16'h0D55, UNITY, UNITY);
        idle(3);

        send_frame(5, 0, 8'd1, 8'd255, 8'd0, 1'b1, 1'b0, 24'h0, 0);
        wait_vld("lat_sat");
        chk_coe("sat_zero", 16'h1FFF, UNITY, UNITY);
        idle(3);

        // Second edge lands 20 cycles into the computation.
        send_frame(4, 0, 8'd10, 8'd20, 8'd30, 1'b1, 1'b0, 24'h0, 0);
        e1 = last_edge;
        idle(15);
        repeat (2) step({8'd255, 8'd1, 8'd255}, 1'b1, 1'b0, 1'b1);
        step(24'h0, 1'b0, 1'b1, 1'b1);
        chk("busy_edge_offset", cyc - e1, 20);
        step(24'h0, 1'b0, 1'b0, 1'b1);
        repeat (4) step({8'd200, 8'd100, 8'd25}, 1'b1, 1'b0, 1'b1);
        while (cyc < e1 + 100) step(24'h0, 1'b0, 1'b0, 1'b1);
        chk_coe("busy_first", 16'h0800, UNITY, 16'h02AA);
        step(24'h0, 1'b0, 1'b1, 1'b1);
        step(24'h0, 1'b0, 1'b0, 1'b1);
        wait_vld("lat_after_busy");
        chk_coe("after_busy", 16'h1000, UNITY, 16'h0200);
        idle(3);

        send_frame(4, 0, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0, 24'h0, 100);
        chk_coe("en_off", 16'h1000, UNITY, 16'h0200);

        // Reset 30 cycles into the R divide.
        send_frame(4, 0, 8'd64, 8'd128, 8'd32, 1'b1, 1'b0, 24'h0, 0);
        idle(28);
        chk("busy_mid_div", busy_o, 1'b1);
        do_reset(3);
        send_frame(4, 0, 8'd64, 8'd128, 8'd32, 1'b1, 1'b0, 24'h0, 100);
        chk_coe("post_rst_unprimed", UNITY, UNITY, UNITY);
        send_frame(4, 0, 8'd64, 8'd128, 8'd32, 1'b1, 1'b0, 24'h0, 0);
        wait_vld("lat_post_rst");
        chk_coe("post_rst", 16'h0800, UNITY, 16'h1000);
        idle(3);

        // Edge-cycle pixel belongs to the next frame only.
        send_frame(4, 0, 8'd100, 8'd100, 8'd100, 1'b1, 1'b1, {8'd100, 8'd100, 8'd200}, 0);
        wait_vld("lat_edge_px_a");
        chk_coe("edge_px_a", UNITY, UNITY, UNITY);
        idle(3);
        send_frame(3, 0, 8'd100, 8'd100, 8'd100, 1'b1, 1'b0, 24'h0, 0);
        wait_vld("lat_edge_px_b");
        chk_coe("edge_px_b", 16'h0333, UNITY, UNITY);
        idle(3);

        for (int f = 0; f < 30; f++) begin
            sel = int'($urandom_range(0, 9));
            mr = 8'hFF; mg = 8'hFF; mb = 8'hFF;
            if (sel == 0) mr = 8'h00;
            if (sel == 1) mb = 8'h00;
            if (sel == 2) mr = 8'h01;
            en = ($urandom_range(0, 5) != 0);
            send_frame(int'($urandom_range(1, 40)), 1'b1, mr, mg, mb, en,
                       1'($urandom_range(0, 1)), 24'($urandom), int'($urandom_range(20, 120)));
        end
        idle(120);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/awb_gray_world.md
# awb_gray_world

Gray-world auto-white-balance gain estimator, placed directly upstream of the per-channel RGB gain multiplier. Every active pixel of a frame is summed per channel. At frame end, the block computes R and B gains that equalise those channels to the G mean, using a shared sequential divider during vertical blanking. It drives the multiplier's coefficient bus with unsigned Q3.10 gains, and the three coefficients update together.

## Interface
- PIXEL_WIDTH, 8, bits per colour component
- COE_WIDTH, 16, width of each coefficient slot on coe_o
- COE_FRACTION_WIDTH, 10, fractional bits of gain; unity = 1<<COE_FRACTION_WIDTH
- SUM_WIDTH, 32, per-channel accumulator width
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low; one clock domain only
- di_i  in  PIXEL_WIDTH*3  pixel; R [PIXEL_WIDTH*0 +: PIXEL_WIDTH], G [*1], B [*2]
- de_i  in  1  active-pixel qualifier
- vs_i  in  1  vertical sync, active-high; rising edge = frame end
- en_i  in  1  1 = gains update at frame end; 0 = coe_o frozen
- coe_o  out  COE_WIDTH*3  gains for R, G, B; bits [COE_WIDTH-1:13] of each slot always 0
- coe_vld_o  out  1  one-cycle pulse on the cycle coe_o changes
- busy_o  out  1  divider running

## Operation
- Accumulation: on each cycle with de_i=1, add each component to its sum; sums saturate at all-ones.
- Frame end (edge cycle): the cycle where vs_i=1 and the registered vs_i is 0.
  - In that cycle, sums are copied to snapshot registers only if state=IDLE, en_i=1 and primed=1.
  - Accumulators restart in that cycle: loaded with the current pixel if de_i=1, otherwise 0.
- primed: cleared by reset, set by the first frame-end edge. The first edge after reset never triggers a computation, because that frame is partial.
- FSM states: IDLE, DIV_R, DIV_B, UPDATE.
  - IDLE -> DIV_R on a snapshot.
  - DIV_R -> DIV_B when the divider is done.
  - DIV_B -> UPDATE when the divider is done.
  - UPDATE -> IDLE after one cycle.
- Divide: gain_x = floor((sumG << COE_FRACTION_WIDTH) / sumX), for X = R, B.
  - Unsigned restoring divider, one quotient bit per cycle, N = SUM_WIDTH + COE_FRACTION_WIDTH cycles per divide.
  - Quotient > 0x1FFF saturates to 0x1FFF.
  - sumX == 0 gives unity (0x400), with no divide fault.
- G gain is constant unity.
- UPDATE writes all three slots of coe_o in one cycle and pulses coe_vld_o.
- A frame-end edge while busy_o=1 is ignored for computation (accumulators still restart); the running computation completes normally.
- en_i is sampled only at the edge cycle. Dropping en_i mid-computation does not abort it.

## Timing
- Reset values:
  - coe_o = {0x400, 0x400, 0x400} (unity)
  - coe_vld_o = 0, busy_o = 0
  - state IDLE, primed 0, sums and snapshots 0
- busy_o = 1 from the cycle after the edge cycle through the UPDATE cycle inclusive.
- Latency: coe_o and coe_vld_o change on clock edge 2N+2 after the edge cycle's clock edge. With defaults this is 86 cycles, which must fit in vblank.
- coe_o holds stable at all other times. The downstream multiplier may sample it on any cycle.
- Asserting reset mid-division aborts the division and restores unity gains immediately (asynchronously).

## Structure
- Package awb_pkg holds:
  - state enum (IDLE, DIV_R, DIV_B, UPDATE)
  - GAIN_UNITY = 0x400
  - GAIN_MAX = 0x1FFF (13-bit limit of the multiplier coefficient)
  - a function for the divider cycle count N
- Sub-module udiv_seq is the parameterised sequential unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient.
  - One instance, shared between R and B.
- The top level holds the accumulators, edge detect, snapshot, FSM, saturation and the output registers.

## Test plan
- Two frames, each 4 px of R=64, G=128, B=32 -> first edge gives no coe_vld_o; second edge gives coe_o R=0x800, G=0x400, B=0x1000, with coe_vld_o 86 cycles after the edge.
- Frame of 2 px, R=3, G=10, B=10 -> R=0xD55 (20480/6 truncated), B=0x400.
- R=1, G=255, B=0 for all pixels -> R saturates to 0x1FFF; B=0x400 via the zero-divisor rule.
- Frame-end edge 20 cycles after a computation starts -> no second coe_vld_o; next frame's sums exclude pre-edge pixels; the following edge computes correctly.
- en_i=0 at an edge -> no busy_o, coe_o unchanged. Assert reset at cycle 30 of DIV_R -> coe_o = unity, busy_o=0, next edge treated as unprimed.
- de_i=1 on the edge cycle with R=200 -> that pixel is counted in the new frame's sum only.
